// File: rtl/m68k_bus_master_if.sv
// Request port and 68k bus pins of the bus master, bundled for connection to the chipset side.
// Direction pins (*_d) read 1 for released/input and 0 for driven.
interface m68k_bus_master_if;
    logic        req;
    logic        req_we;
    logic [22:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        busy;
    logic        ack;
    logic        berr;
    logic [15:0] rdata;
    logic [22:0] VA_o;
    logic        VA_d;
    logic [15:0] VD_i;
    logic [15:0] VD_o;
    logic        VD_d;
    logic        AS_o;
    logic        UDS_o;
    logic        LDS_o;
    logic        RW_o;
    logic        strobe_d;
    logic        DTACK_i;
    logic        BR_i;
    logic        BGACK_i;
    logic        BG_o;

    modport master (
        input  req, req_we, req_addr, req_wdata, req_be,
        input  VD_i, DTACK_i, BR_i, BGACK_i,
        output busy, ack, berr, rdata,
        output VA_o, VA_d, VD_o, VD_d,
        output AS_o, UDS_o, LDS_o, RW_o, strobe_d, BG_o
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, req_be,
        output VD_i, DTACK_i, BR_i, BGACK_i,
        input  busy, ack, berr, rdata,
        input  VA_o, VA_d, VD_o, VD_d,
        input  AS_o, UDS_o, LDS_o, RW_o, strobe_d, BG_o
    );
endinterface

// File: rtl/m68k_bus_master.sv
// 68000-style bus cycle initiator: runs S0..S7 asynchronous bus cycles paced by CLK_i edges
// seen in the MCLK domain, and hands the bus over to BR_i/BGACK_i requesters between cycles.
module m68k_bus_master #(
    parameter int TIMEOUT = 128
) (
    input  logic                MCLK,
    input  logic                SRES,
    input  logic                CLK_i,
    m68k_bus_master_if.master   bus
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, S0, S1, S2, S3, S4, S5, S6, S7, GRANT
    } state_t;

    state_t       state_q, state_d;
    logic         clk_q;
    logic         rise, fall;

    logic         we_q, we_d;
    logic [22:0]  addr_q, addr_d;
    logic [15:0]  wdata_q, wdata_d;
    logic [1:0]   be_q, be_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic         busy_q, busy_d;
    logic         ack_q, ack_d;
    logic         berr_q, berr_d;
    logic [15:0]  rdata_q, rdata_d;
    logic [22:0]  vaddr_q, vaddr_d;
    logic         vadir_q, vadir_d;
    logic [15:0]  vdout_q, vdout_d;
    logic         vddir_q, vddir_d;
    logic         as_q, as_d;
    logic         uds_q, uds_d;
    logic         lds_q, lds_d;
    logic         rw_q, rw_d;
    logic         strdir_q, strdir_d;
    logic         bg_q, bg_d;

    logic         start_cycle, start_grant, release_bus;

    // The edge detector keeps running through reset so no false edge appears on release.
    always_ff @(posedge MCLK) begin
        clk_q <= CLK_i;
    end

    assign rise = CLK_i & ~clk_q;
    assign fall = ~CLK_i & clk_q;

    always_ff @(posedge MCLK) begin
        if (!SRES) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= 2'b11;
            wcnt_q   <= '0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            berr_q   <= 1'b0;
            rdata_q  <= '0;
            vaddr_q  <= '0;
            vadir_q  <= 1'b1;
            vdout_q  <= '0;
            vddir_q  <= 1'b1;
            as_q     <= 1'b1;
            uds_q    <= 1'b1;
            lds_q    <= 1'b1;
            rw_q     <= 1'b1;
            strdir_q <= 1'b1;
            bg_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            wcnt_q   <= wcnt_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            berr_q   <= berr_d;
            rdata_q  <= rdata_d;
            vaddr_q  <= vaddr_d;
            vadir_q  <= vadir_d;
            vdout_q  <= vdout_d;
            vddir_q  <= vddir_d;
            as_q     <= as_d;
            uds_q    <= uds_d;
            lds_q    <= lds_d;
            rw_q     <= rw_d;
            strdir_q <= strdir_d;
            bg_q     <= bg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        wcnt_d      = wcnt_q;
        busy_d      = busy_q;
        ack_d       = 1'b0;
        berr_d      = 1'b0;
        rdata_d     = rdata_q;
        vaddr_d     = vaddr_q;
        vadir_d     = vadir_q;
        vdout_d     = vdout_q;
        vddir_d     = vddir_q;
        as_d        = as_q;
        uds_d       = uds_q;
        lds_d       = lds_q;
        rw_d        = rw_q;
        strdir_d    = strdir_q;
        bg_d        = bg_q;
        start_cycle = 1'b0;
        start_grant = 1'b0;
        release_bus = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    if (!bus.BR_i) begin
                        start_grant = 1'b1;
                    end else if (bus.req) begin
                        start_cycle = 1'b1;
                    end
                end
            end
            S0: begin
                if (fall) begin
                    state_d = S1;
                    vadir_d = 1'b0;
                    vaddr_d = addr_q;
                end
            end
            S1: begin
                if (rise) begin
                    state_d = S2;
                    as_d    = 1'b0;
                    if (!we_q) begin
                        uds_d = ~be_q[1];
                        lds_d = ~be_q[0];
                    end
                end
            end
            S2: begin
                if (fall) begin
                    state_d = S3;
                    if (we_q) begin
                        vddir_d = 1'b0;
                        vdout_d = wdata_q;
                    end
                end
            end
            S3: begin
                if (rise) begin
                    state_d = S4;
                    if (we_q) begin
                        uds_d = ~be_q[1];
                        lds_d = ~be_q[0];
                    end
                end
            end
            S4: begin
                // Every rise seen while still in S4 belongs to a wait state.
                if (rise) begin
                    wcnt_d = wcnt_q + WCW'(1);
                end else if (fall) begin
                    if (!bus.DTACK_i) begin
                        state_d = S5;
                    end else if (wcnt_q == WCW'(TIMEOUT)) begin
                        state_d     = IDLE;
                        as_d        = 1'b1;
                        uds_d       = 1'b1;
                        lds_d       = 1'b1;
                        berr_d      = 1'b1;
                        busy_d      = 1'b0;
                        release_bus = 1'b1;
                    end
                end
            end
            S5: begin
                if (rise) begin
                    state_d = S6;
                end
            end
            S6: begin
                if (fall) begin
                    state_d = S7;
                    if (!we_q) begin
                        rdata_d = bus.VD_i;
                    end
                    as_d   = 1'b1;
                    uds_d  = 1'b1;
                    lds_d  = 1'b1;
                    ack_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S7: begin
                if (rise) begin
                    release_bus = 1'b1;
                    state_d     = IDLE;
                    if (!bus.BR_i) begin
                        start_grant = 1'b1;
                    end else if (bus.req) begin
                        start_cycle = 1'b1;
                    end
                end
            end
            GRANT: begin
                // Returning to IDLE here guarantees a full CLK_i period before the next accept.
                if (rise && bus.BR_i && bus.BGACK_i) begin
                    bg_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (release_bus) begin
            vadir_d  = 1'b1;
            vddir_d  = 1'b1;
            strdir_d = 1'b1;
            rw_d     = 1'b1;
        end

        if (start_grant) begin
            state_d = GRANT;
            bg_d    = 1'b0;
        end

        if (start_cycle) begin
            state_d  = S0;
            we_d     = bus.req_we;
            addr_d   = bus.req_addr;
            wdata_d  = bus.req_wdata;
            be_d     = (bus.req_be == 2'b00) ? 2'b11 : bus.req_be;
            wcnt_d   = '0;
            busy_d   = 1'b1;
            strdir_d = 1'b0;
            rw_d     = ~bus.req_we;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.ack      = ack_q;
    assign bus.berr     = berr_q;
    assign bus.rdata    = rdata_q;
    assign bus.VA_o     = vaddr_q;
    assign bus.VA_d     = vadir_q;
    assign bus.VD_o     = vdout_q;
    assign bus.VD_d     = vddir_q;
    assign bus.AS_o     = as_q;
    assign bus.UDS_o    = uds_q;
    assign bus.LDS_o    = lds_q;
    assign bus.RW_o     = rw_q;
    assign bus.strobe_d = strdir_q;
    assign bus.BG_o     = bg_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Bench for m68k_bus_master: a DTACK responder with programmable wait states plus a
// transaction-level model predicting latency, bus pin values, ack/berr and rdata.
module tb_m68k_bus_master;

    localparam int TIMEOUT  = 16;
    localparam int W_BUSY   = 0;
    localparam int W_ACK    = 1;
    localparam int W_ASLOW  = 2;
    localparam int W_BGLOW  = 3;
    localparam int W_BGHIGH = 4;

    logic MCLK = 1'b0;
    logic SRES = 1'b0;
    logic CLK_i = 1'b0;
    int   cyc = 0;

    int   checks = 0;
    int   failures = 0;
    int   respWaits = 0;
    logic [15:0] rdataModel = 16'h0000;

    bit          snapValid = 1'b0;
    logic [22:0] snapVA;
    logic        snapVAd, snapAS, snapUDS, snapLDS, snapRW, snapStrd, snapVDd;
    logic [15:0] snapVDo;

    m68k_bus_master_if bus ();

    m68k_bus_master #(.TIMEOUT(TIMEOUT)) dut (
        .MCLK  (MCLK),
        .SRES  (SRES),
        .CLK_i (CLK_i),
        .bus   (bus)
    );

    initial forever #5 MCLK = ~MCLK;

    // CLK_i runs at one eighth of MCLK and changes just after a rising MCLK edge.
    initial begin
        forever begin
            repeat (4) @(posedge MCLK);
            #2 CLK_i = ~CLK_i;
        end
    end

    always @(posedge MCLK) cyc <= cyc + 1;

    // Responder: counts CLK_i rises after AS goes low, pulls DTACK low for the requested
    // number of wait states and snapshots the bus while the strobes are asserted.
    initial begin
        bit asLow;
        bit prevClk;
        int rises;
        bus.DTACK_i = 1'b1;
        asLow = 1'b0;
        prevClk = 1'b0;
        rises = 0;
        forever begin
            @(negedge MCLK);
            if (bus.AS_o) begin
                bus.DTACK_i = 1'b1;
                asLow = 1'b0;
                rises = 0;
            end else if (!asLow) begin
                asLow = 1'b1;
                rises = 0;
            end else if (CLK_i && !prevClk) begin
                rises++;
                if (rises == 2) begin
                    snapVA   = bus.VA_o;
                    snapVAd  = bus.VA_d;
                    snapAS   = bus.AS_o;
                    snapUDS  = bus.UDS_o;
                    snapLDS  = bus.LDS_o;
                    snapRW   = bus.RW_o;
                    snapStrd = bus.strobe_d;
                    snapVDd  = bus.VD_d;
                    snapVDo  = bus.VD_o;
                    snapValid = 1'b1;
                end
                if (rises == 1 + respWaits) bus.DTACK_i = 1'b0;
            end
            prevClk = CLK_i;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitFor(input int what, input int limit, output bit seen, output int atCyc);
        seen = 1'b0;
        atCyc = 0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge MCLK);
            case (what)
                W_BUSY:   seen = (bus.busy == 1'b1);
                W_ACK:    seen = (bus.ack == 1'b1);
                W_ASLOW:  seen = (bus.AS_o == 1'b0);
                W_BGLOW:  seen = (bus.BG_o == 1'b0);
                W_BGHIGH: seen = (bus.BG_o == 1'b1);
                default:  seen = 1'b0;
            endcase
            atCyc = cyc;
        end
    endtask

    task automatic checkIdleBus(input string tag);
        checkOutput({tag, "_AS"}, bus.AS_o, 1);
        checkOutput({tag, "_UDS"}, bus.UDS_o, 1);
        checkOutput({tag, "_LDS"}, bus.LDS_o, 1);
        checkOutput({tag, "_RW"}, bus.RW_o, 1);
        checkOutput({tag, "_strobe_d"}, bus.strobe_d, 1);
        checkOutput({tag, "_VA_d"}, bus.VA_d, 1);
        checkOutput({tag, "_VD_d"}, bus.VD_d, 1);
    endtask

    // One complete request: model predicts outcome, latency and mid-cycle pin values.
    task automatic applyStimulus(input logic we, input logic [22:0] addr, input logic [15:0] wdata,
                                 input logic [1:0] be, input int waits, input logic [15:0] vd);
        logic [1:0] beEff;
        logic expRW, expUDS, expLDS, expVDd;
        bit expOk, gotBusy, gotAck, gotBerr;
        int accCyc, endCyc, expLat;
        beEff  = (be == 2'b00) ? 2'b11 : be;
        expOk  = (waits <= TIMEOUT);
        expRW  = ~we;
        expUDS = ~beEff[1];
        expLDS = ~beEff[0];
        expVDd = ~we;
        expLat = expOk ? (28 + 8 * waits) : (20 + 8 * TIMEOUT);
        respWaits = waits;
        bus.VD_i = vd;
        snapValid = 1'b0;
        @(negedge MCLK);
        bus.req_we = we;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        bus.req_be = be;
        bus.req = 1'b1;
        waitFor(W_BUSY, 64, gotBusy, accCyc);
        bus.req = 1'b0;
        checkOutput("busy_seen", gotBusy, 1);
        if (!gotBusy) return;
        gotAck = 1'b0;
        gotBerr = 1'b0;
        endCyc = accCyc;
        for (int n = 0; n < 400 && !gotAck && !gotBerr; n++) begin
            @(negedge MCLK);
            gotAck = bus.ack;
            gotBerr = bus.berr;
            endCyc = cyc;
        end
        checkOutput("ack", gotAck, expOk);
        checkOutput("berr", gotBerr, !expOk);
        checkOutput("latency", endCyc - accCyc, expLat);
        checkOutput("busy_end", bus.busy, 0);
        if (expOk && !we) rdataModel = vd;
        checkOutput("snap_valid", snapValid, 1);
        if (snapValid) begin
            checkOutput("VA_o", snapVA, addr);
            checkOutput("VA_d", snapVAd, 0);
            checkOutput("AS_o", snapAS, 0);
            checkOutput("RW_o", snapRW, expRW);
            checkOutput("strobe_d", snapStrd, 0);
            checkOutput("UDS_o", snapUDS, expUDS);
            checkOutput("LDS_o", snapLDS, expLDS);
            checkOutput("VD_d", snapVDd, expVDd);
            if (we) checkOutput("VD_o", snapVDo, wdata);
        end
        @(negedge MCLK);
        checkOutput("pulse_width", bus.ack | bus.berr, 0);
        checkOutput("rdata", bus.rdata, rdataModel);
        repeat (8) @(negedge MCLK);
        checkOutput("post_AS", bus.AS_o, 1);
        checkOutput("post_UDS", bus.UDS_o, 1);
        checkOutput("post_LDS", bus.LDS_o, 1);
        if (expOk) checkIdleBus("post");
        checkOutput("post_BG", bus.BG_o, 1);
    endtask

    initial begin
        bit seen;
        int c0, c1;
        int lowCnt;
        logic [22:0] a;
        logic [15:0] d, v;

        bus.req = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_be = 2'b11;
        bus.VD_i = '0;
        bus.BR_i = 1'b1;
        bus.BGACK_i = 1'b1;
        SRES = 1'b0;
        repeat (4) @(negedge MCLK);
        checkIdleBus("reset");
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_ack", bus.ack, 0);
        checkOutput("reset_berr", bus.berr, 0);
        checkOutput("reset_rdata", bus.rdata, 0);
        checkOutput("reset_BG", bus.BG_o, 1);
        SRES = 1'b1;
        repeat (4) @(negedge MCLK);

        $display("[TB] zero-wait read");
        applyStimulus(1'b0, 23'h300000, 16'h0000, 2'b11, 0, 16'hBEEF);

        $display("[TB] lower-byte write with three wait states");
        applyStimulus(1'b1, 23'h012345, 16'h1234, 2'b01, 3, 16'hFFFF);

        $display("[TB] DTACK timeout then normal read");
        applyStimulus(1'b0, 23'h00ABCD, 16'h0000, 2'b11, 1000, 16'h7777);
        applyStimulus(1'b0, 23'h100002, 16'h0000, 2'b00, 1, 16'hC3A5);

        $display("[TB] bus request during a cycle");
        respWaits = 1;
        v = 16'h5A5A;
        bus.VD_i = v;
        snapValid = 1'b0;
        @(negedge MCLK);
        bus.req_we = 1'b0;
        bus.req_addr = 23'h222222;
        bus.req_be = 2'b11;
        bus.req = 1'b1;
        waitFor(W_BUSY, 64, seen, c0);
        bus.req = 1'b0;
        checkOutput("arb_busy_seen", seen, 1);
        waitFor(W_ASLOW, 64, seen, c1);
        checkOutput("arb_as_seen", seen, 1);
        bus.BR_i = 1'b0;
        waitFor(W_ACK, 200, seen, c1);
        checkOutput("arb_ack_seen", seen, 1);
        checkOutput("arb_bg_at_ack", bus.BG_o, 1);
        rdataModel = v;
        waitFor(W_BGLOW, 64, seen, c1);
        checkOutput("arb_bg_low_seen", seen, 1);
        checkOutput("arb_grant_latency", c1 - c0, 32 + 8 * 1);
        checkIdleBus("arb_grant");
        checkOutput("arb_rdata", bus.rdata, rdataModel);
        respWaits = 0;
        v = 16'h0F1E;
        bus.VD_i = v;
        bus.req_addr = 23'h333333;
        bus.req = 1'b1;
        repeat (16) @(negedge MCLK);
        checkOutput("arb_queued_busy", bus.busy, 0);
        checkOutput("arb_bg_held", bus.BG_o, 0);
        bus.BGACK_i = 1'b0;
        repeat (16) @(negedge MCLK);
        bus.BR_i = 1'b1;
        repeat (16) @(negedge MCLK);
        checkOutput("arb_bg_during_bgack", bus.BG_o, 0);
        checkOutput("arb_busy_during_bgack", bus.busy, 0);
        bus.BGACK_i = 1'b1;
        waitFor(W_BGHIGH, 32, seen, c0);
        checkOutput("arb_bg_release_seen", seen, 1);
        waitFor(W_BUSY, 64, seen, c1);
        bus.req = 1'b0;
        checkOutput("arb_queued_accept_seen", seen, 1);
        checkOutput("arb_queued_delay", c1 - c0, 8);
        waitFor(W_ACK, 200, seen, c1);
        checkOutput("arb_queued_ack", seen, 1);
        rdataModel = v;
        @(negedge MCLK);
        checkOutput("arb_queued_rdata", bus.rdata, rdataModel);
        repeat (8) @(negedge MCLK);

        $display("[TB] short bus request pulse in idle");
        lowCnt = 0;
        @(negedge MCLK);
        bus.BR_i = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge MCLK);
            if (!bus.BG_o) lowCnt++;
        end
        bus.BR_i = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge MCLK);
            if (!bus.BG_o) lowCnt++;
        end
        checkOutput("br_pulse_bg_low_mclks", lowCnt, 8);
        applyStimulus(1'b1, 23'h044444, 16'hA55A, 2'b10, 0, 16'h0000);

        $display("[TB] reset in the middle of a write");
        respWaits = 1000;
        snapValid = 1'b0;
        @(negedge MCLK);
        bus.req_we = 1'b1;
        bus.req_addr = 23'h055555;
        bus.req_wdata = 16'h9999;
        bus.req_be = 2'b11;
        bus.req = 1'b1;
        waitFor(W_BUSY, 64, seen, c0);
        bus.req = 1'b0;
        checkOutput("rst_busy_seen", seen, 1);
        for (int n = 0; n < 64 && !snapValid; n++) @(negedge MCLK);
        checkOutput("rst_in_s4", snapValid, 1);
        SRES = 1'b0;
        @(negedge MCLK);
        SRES = 1'b1;
        checkIdleBus("rst_mid");
        checkOutput("rst_mid_busy", bus.busy, 0);
        checkOutput("rst_mid_BG", bus.BG_o, 1);
        rdataModel = 16'h0000;
        checkOutput("rst_mid_rdata", bus.rdata, rdataModel);
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge MCLK);
            if (bus.ack || bus.berr) seen = 1'b1;
        end
        checkOutput("rst_no_ack_berr", seen, 0);
        applyStimulus(1'b0, 23'h066666, 16'h0000, 2'b11, 2, 16'h4321);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 10; i++) begin
            a = 23'($urandom);
            d = 16'($urandom);
            v = 16'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), a, d, 2'($urandom_range(0, 3)),
                          $urandom_range(0, 4), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
